// File: rtl/detect_event_counter_pkg.sv
// det_count_pkg: shared constants for the detection event counter.
//   BCD_MAX    largest legal value of a BCD digit
//   SEG_DIGIT  active-low 7-segment glyphs for 0..9, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK  all segments off (active-low)
package det_count_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg7_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  localparam seg7_t SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam seg7_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/detect_event_counter_bcd_to_seg7.sv
// bcd_to_seg7: combinational decode of one BCD digit to active-low segments.
// Ports:
//   bcd    in   4  BCD digit; values above 9 display blank
//   seg_n  out  7  active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg7
  import det_count_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    for (int d = 0; d <= 9; d++) begin
      if (bcd == 4'(d)) seg_n = SEG_DIGIT[d];
    end
  end

endmodule

// File: rtl/detect_event_counter.sv
// detect_event_counter: counts rising edges of the sequence detector's match
// level as a DIGITS-wide BCD number, strobes event_pulse with each count
// update, flags a sticky overflow past all-9s and drives 7-segment displays.
// Optional feature macro: DETECT_COUNT_SAT_EN
//   defined   -> count holds at all-9s on overflow
//   undefined -> count wraps to 0 on overflow (default)
// Ports:
//   clock        in   1         system clock, rising edge
//   reset        in   1         asynchronous active-high reset
//   clear        in   1         synchronous clear of count and overflow
//   detect_in    in   1         detector match level
//   count_bcd    out  4*DIGITS  BCD count, digit 0 in [3:0]
//   event_pulse  out  1         one-cycle strobe with each count update
//   overflow     out  1         sticky overflow flag
//   hex_n        out  7*DIGITS  active-low segments, digit 0 in [6:0]
module detect_event_counter
  import det_count_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  detect_in,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  event_pulse,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex_n
);

  logic                prev_detect;
  logic                rise;
  logic                terminal;
  logic                carry;
  logic [4*DIGITS-1:0] count_inc;
  logic [4*DIGITS-1:0] count_next;

  assign rise = detect_in & ~prev_detect;

  // Per-digit ripple increment: a digit at 9 rolls to 0 and passes the carry on.
  always_comb begin
    count_inc = count_bcd;
    carry     = 1'b1;
    terminal  = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (count_bcd[4*i +: 4] != BCD_MAX) terminal = 1'b0;
      if (carry) begin
        if (count_bcd[4*i +: 4] == BCD_MAX) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

`ifdef DETECT_COUNT_SAT_EN
  assign count_next = terminal ? count_bcd : count_inc;
`else
  // All-9s increments naturally ripple back to all-0s.
  assign count_next = count_inc;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_detect <= 1'b0;
      count_bcd   <= '0;
      event_pulse <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      prev_detect <= detect_in;
      if (clear) begin
        // Clear wins over a simultaneous rise; that event is lost.
        count_bcd   <= '0;
        event_pulse <= 1'b0;
        overflow    <= 1'b0;
      end else begin
        event_pulse <= rise;
        if (rise) begin
          count_bcd <= count_next;
          if (terminal) overflow <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_seg
    bcd_to_seg7 u_seg (
      .bcd   (count_bcd[4*g +: 4]),
      .seg_n (hex_n[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_detect_event_counter.sv
module tb_detect_event_counter;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        detect_in;
  logic [7:0]  count_bcd;
  logic        event_pulse;
  logic        overflow;
  logic [13:0] hex_n;

  int checks = 0;
  int errors = 0;

  // reference model: count as a plain integer 0..99
  int   m_count;
  bit   m_ovf;
  bit   m_pulse;
  bit   m_prev;
  int   pulses_seen;

`ifdef DETECT_COUNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  detect_event_counter #(.DIGITS(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .detect_in   (detect_in),
    .count_bcd   (count_bcd),
    .event_pulse (event_pulse),
    .overflow    (overflow),
    .hex_n       (hex_n)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".count"}, 32'(count_bcd), 32'(to_bcd(m_count)));
    chk({tag, ".pulse"}, 32'(event_pulse), 32'(m_pulse));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".hex"}, 32'(hex_n), 32'({glyph(m_count / 10), glyph(m_count % 10)}));
  endtask

  task automatic model_reset();
    m_count = 0;
    m_ovf   = 1'b0;
    m_pulse = 1'b0;
    m_prev  = 1'b0;
  endtask

  // Called at posedge+1: apply inputs, advance the model, clock, check.
  task automatic cycle(input bit clr, input bit det, input string tag);
    bit r;
    clear     = clr;
    detect_in = det;
    r = det && !m_prev;
    m_prev = det;
    if (clr) begin
      m_count = 0;
      m_ovf   = 1'b0;
      m_pulse = 1'b0;
    end else begin
      m_pulse = r;
      if (r) begin
        if (m_count == 99) begin
          m_ovf = 1'b1;
          if (!SAT) m_count = 0;
        end else begin
          m_count = m_count + 1;
        end
      end
    end
    @(posedge clock);
    #1;
    if (event_pulse === 1'b1) pulses_seen++;
    check_outputs(tag);
  endtask

  task automatic events(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b1, tag);
      cycle(1'b0, 1'b0, tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    detect_in = 1'b0;
    model_reset();

    // 1: reset holds everything while detect_in toggles
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      detect_in = ~detect_in;
      check_outputs("rst_hold");
    end
    detect_in = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cycle(1'b0, 1'b0, "rst_rel");
    cycle(1'b0, 1'b0, "rst_rel");

    // 2: long level = one event
    pulses_seen = 0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, "lvl_hi5");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "lvl_lo3");
    cycle(1'b0, 1'b1, "lvl_hi1");
    cycle(1'b0, 1'b0, "lvl_end");
    chk("lvl.count_const", 32'(count_bcd), 32'h02);
    chk("lvl.pulses", 32'(pulses_seen), 32'd2);

    // 3: carry into the tens digit
    cycle(1'b1, 1'b0, "clr3");
    events(9, "ev9");
    chk("ev9.const", 32'(count_bcd), 32'h09);
    events(1, "ev10");
    chk("ev10.const", 32'(count_bcd), 32'h10);
    chk("ev10.hex1", 32'(hex_n[13:7]), 32'h79);

    // 4: overflow past 99
    cycle(1'b1, 1'b0, "clr4");
    events(99, "ev99");
    chk("ev99.const", 32'(count_bcd), 32'h99);
    chk("ev99.ovf", 32'(overflow), 32'd0);
    events(1, "ev100");
    chk("ovf.count_const", 32'(count_bcd), SAT ? 32'h99 : 32'h00);
    chk("ovf.flag", 32'(overflow), 32'd1);
    events(2, "post_ovf");

    // 5: clear beats a simultaneous rise
    cycle(1'b1, 1'b0, "clr5");
    events(5, "ev5");
    cycle(1'b1, 1'b1, "clr_rise");
    chk("clr_rise.pulse", 32'(event_pulse), 32'd0);
    chk("clr_rise.count", 32'(count_bcd), 32'h00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, "held_after_clr");
    chk("held.count", 32'(count_bcd), 32'h00);
    cycle(1'b0, 1'b0, "drop5");

    // 6: async reset between edges at count 37 (overflow set in wrap mode)
    if (SAT) cycle(1'b1, 1'b0, "clr6");
    else begin
      events(99, "to99");
      events(1, "wrap");
    end
    events(37, "ev37");
    chk("ev37.const", 32'(count_bcd), 32'h37);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async.count", 32'(count_bcd), 32'h00);
    chk("async.ovf", 32'(overflow), 32'd0);
    chk("async.hex", 32'(hex_n), 32'h2040);
    @(posedge clock);
    #1;

    // detect already high when reset releases -> one event
    detect_in = 1'b1;
    reset = 1'b0;
    cycle(1'b0, 1'b1, "hi_at_rel");
    chk("hi_at_rel.pulse", 32'(event_pulse), 32'd1);
    cycle(1'b0, 1'b1, "hi_at_rel2");
    chk("hi_at_rel2.count", 32'(count_bcd), 32'h01);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
